// File: rtl/text_sequencer.sv
// Walks a character string from a synchronous buffer and hands each printable
// glyph to a character renderer, tracking a text cursor with column wrap.
`ifndef X_BITES
`define X_BITES 10
`endif
`ifndef Y_BITES
`define Y_BITES 10
`endif
`ifndef SQUARE_BITES
`define SQUARE_BITES 4
`endif
`ifndef CHAR_BITES
`define CHAR_BITES 8
`endif

module text_sequencer #(
    parameter int MAX_LEN   = 64,
    parameter int COL_PITCH = 6,
    parameter int ROW_PITCH = 8,
    localparam int ADDR_W   = $clog2(MAX_LEN)
) (
    input  logic                     clock,
    input  logic                     resetn,
    input  logic                     start,
    input  logic                     abort,
    input  logic [ADDR_W:0]          text_len,
    input  logic [`X_BITES-1:0]      base_x,
    input  logic [`Y_BITES-1:0]      base_y,
    input  logic [`SQUARE_BITES-1:0] size,
    input  logic [7:0]               cols_per_line,
    input  logic [7:0]               max_rows,
    output logic [ADDR_W-1:0]        mem_addr,
    input  logic [`CHAR_BITES-1:0]   mem_data,
    output logic [`CHAR_BITES-1:0]   char_out,
    output logic [`X_BITES-1:0]      cr_origin_x,
    output logic [`Y_BITES-1:0]      cr_origin_y,
    output logic                     cr_enable,
    input  logic                     cr_finished,
    output logic                     busy,
    output logic                     done,
    output logic                     truncated
);
    localparam int XW = `X_BITES;
    localparam int YW = `Y_BITES;
    localparam int CW = `CHAR_BITES;

    typedef enum logic [2:0] {
        IDLE, FETCH, WAIT, DECODE, DRAW, RELEASE, ADVANCE, FINISH
    } state_t;

    state_t                   state;
    logic [ADDR_W:0]          idx, len_q;
    logic [XW-1:0]            bx_q, cur_x;
    logic [YW-1:0]            cur_y;
    logic [`SQUARE_BITES-1:0] size_q;
    logic [7:0]               cols_q, rows_q, col, row;
    logic                     nl, abort_q, rel_cnt;

    logic [31:0]     step_x, step_y;
    logic [8:0]      col_inc, row_inc;
    logic [ADDR_W:0] idx_inc;
    logic            wrap, is_nl, is_blank;

    // Full-width products; the cursor sums are truncated afterwards so they wrap.
    assign step_x   = 32'(size_q) * 32'(COL_PITCH);
    assign step_y   = 32'(size_q) * 32'(ROW_PITCH);
    assign col_inc  = {1'b0, col} + 9'd1;
    assign row_inc  = {1'b0, row} + 9'd1;
    assign idx_inc  = idx + {{ADDR_W{1'b0}}, 1'b1};
    assign wrap     = nl || (col_inc >= {1'b0, cols_q});
    assign is_nl    = (mem_data == CW'(8'h0A));
    assign is_blank = (mem_data <= CW'(8'h20));

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state       <= IDLE;
            idx         <= '0;
            len_q       <= '0;
            bx_q        <= '0;
            cur_x       <= '0;
            cur_y       <= '0;
            size_q      <= '0;
            cols_q      <= '0;
            rows_q      <= '0;
            col         <= '0;
            row         <= '0;
            nl          <= 1'b0;
            abort_q     <= 1'b0;
            rel_cnt     <= 1'b0;
            mem_addr    <= '0;
            char_out    <= '0;
            cr_origin_x <= '0;
            cr_origin_y <= '0;
            cr_enable   <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            truncated   <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start && !abort) begin
                        len_q     <= text_len;
                        bx_q      <= base_x;
                        cur_x     <= base_x;
                        cur_y     <= base_y;
                        size_q    <= size;
                        cols_q    <= cols_per_line;
                        rows_q    <= max_rows;
                        idx       <= '0;
                        col       <= '0;
                        row       <= '0;
                        truncated <= 1'b0;
                        abort_q   <= 1'b0;
                        busy      <= 1'b1;
                        state     <= (text_len == '0) ? FINISH : FETCH;
                    end
                end
                FETCH: begin
                    mem_addr <= idx[ADDR_W-1:0];
                    state    <= abort ? FINISH : WAIT;
                end
                WAIT: state <= abort ? FINISH : DECODE;
                DECODE: begin
                    if (abort) begin
                        state <= FINISH;
                    end else begin
                        char_out <= mem_data;
                        nl       <= is_nl;
                        if (is_blank) begin
                            state <= ADVANCE;
                        end else begin
                            cr_origin_x <= cur_x;
                            cr_origin_y <= cur_y;
                            cr_enable   <= 1'b1;
                            state       <= DRAW;
                        end
                    end
                end
                DRAW: begin
                    // Abort cannot cut a glyph short; it is remembered until the renderer is released.
                    if (abort) abort_q <= 1'b1;
                    if (cr_finished) begin
                        cr_enable <= 1'b0;
                        rel_cnt   <= 1'b0;
                        state     <= RELEASE;
                    end
                end
                RELEASE: begin
                    if (abort) abort_q <= 1'b1;
                    if (rel_cnt) state <= (abort_q || abort) ? FINISH : ADVANCE;
                    else         rel_cnt <= 1'b1;
                end
                ADVANCE: begin
                    if (abort) begin
                        state <= FINISH;
                    end else begin
                        idx <= idx_inc;
                        if (wrap) begin
                            col   <= '0;
                            cur_x <= bx_q;
                            row   <= row_inc[7:0];
                            cur_y <= YW'(32'(cur_y) + step_y);
                        end else begin
                            col   <= col_inc[7:0];
                            cur_x <= XW'(32'(cur_x) + step_x);
                        end
                        if (idx_inc == len_q) begin
                            state <= FINISH;
                        end else if (wrap && row_inc == {1'b0, rows_q}) begin
                            truncated <= 1'b1;
                            state     <= FINISH;
                        end else begin
                            state <= FETCH;
                        end
                    end
                end
                FINISH: begin
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_text_sequencer.sv
// Directed bench: table of strings with hand-computed draw origins, plus
// hand sequences for empty text, abort mid-draw, reset mid-draw and start-while-busy.
module tb_text_sequencer;
    logic        clock = 1'b0;
    logic        resetn = 1'b0;
    logic        start = 1'b0, abort = 1'b0;
    logic [6:0]  text_len = '0;
    logic [9:0]  base_x = '0, base_y = '0;
    logic [3:0]  size = '0;
    logic [7:0]  cols_per_line = 8'd8, max_rows = 8'd8;
    logic [5:0]  mem_addr;
    logic [7:0]  mem_data = '0;
    logic [7:0]  char_out;
    logic [9:0]  cr_origin_x, cr_origin_y;
    logic        cr_enable, cr_finished = 1'b0;
    logic        busy, done, truncated;

    text_sequencer dut (
        .clock(clock), .resetn(resetn), .start(start), .abort(abort),
        .text_len(text_len), .base_x(base_x), .base_y(base_y), .size(size),
        .cols_per_line(cols_per_line), .max_rows(max_rows),
        .mem_addr(mem_addr), .mem_data(mem_data), .char_out(char_out),
        .cr_origin_x(cr_origin_x), .cr_origin_y(cr_origin_y),
        .cr_enable(cr_enable), .cr_finished(cr_finished),
        .busy(busy), .done(done), .truncated(truncated)
    );

    always #5 clock = ~clock;

    // String buffer with one-cycle read latency.
    logic [7:0] mem [64];
    always @(posedge clock) mem_data <= mem[mem_addr];

    // Renderer: finishes on the third cycle of cr_enable.
    int rcnt = 0;
    always @(posedge clock) begin
        if (cr_enable && !cr_finished) begin
            if (rcnt == 2) begin cr_finished <= 1'b1; rcnt <= 0; end
            else rcnt <= rcnt + 1;
        end else begin
            cr_finished <= 1'b0;
            rcnt        <= 0;
        end
    end

    logic [9:0] dx[$], dy[$];
    logic [7:0] dc[$];
    logic       en_p = 1'b0, en_pp = 1'b0;
    int         done_cnt = 0, rise_viol = 0;
    always @(negedge clock) begin
        if (cr_enable && !en_p) begin
            dx.push_back(cr_origin_x);
            dy.push_back(cr_origin_y);
            dc.push_back(char_out);
            if (en_pp) rise_viol <= rise_viol + 1;
        end
        if (done) done_cnt <= done_cnt + 1;
        en_p  <= cr_enable;
        en_pp <= en_p;
    end

    int nchk = 0, nerr = 0;
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    typedef struct packed {
        logic [7:0][7:0] txt;
        logic [6:0]      len;
        logic [9:0]      bx, by;
        logic [3:0]      sz;
        logic [7:0]      cols, rows;
        int              nd;
        logic [3:0][7:0] ec;
        logic [3:0][9:0] ex, ey;
        logic            tr;
    } vec_t;

    function automatic vec_t mk(input string s, input string d, input int bx, input int by,
                                input int sz, input int c, input int r,
                                input int x0, input int y0, input int x1, input int y1,
                                input int x2, input int y2, input bit tr);
        vec_t v;
        v = '0;
        for (int i = 0; i < s.len(); i++) v.txt[i] = s[i];
        for (int i = 0; i < d.len(); i++) v.ec[i] = d[i];
        v.len = 7'(s.len());
        v.nd  = d.len();
        v.bx = 10'(bx); v.by = 10'(by); v.sz = 4'(sz);
        v.cols = 8'(c); v.rows = 8'(r);
        v.ex[0] = 10'(x0); v.ey[0] = 10'(y0);
        v.ex[1] = 10'(x1); v.ey[1] = 10'(y1);
        v.ex[2] = 10'(x2); v.ey[2] = 10'(y2);
        v.tr = tr;
        return v;
    endfunction

    task automatic launch(input vec_t v);
        for (int i = 0; i < 64; i++) mem[i] = (i < 8) ? v.txt[i] : 8'h00;
        dx.delete(); dy.delete(); dc.delete();
        done_cnt = 0;
        @(negedge clock);
        text_len = v.len; base_x = v.bx; base_y = v.by; size = v.sz;
        cols_per_line = v.cols; max_rows = v.rows;
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
    endtask

    task automatic wait_done(input string nm);
        int t = 0;
        while (!done && t < 3000) begin @(negedge clock); t++; end
        if (t >= 3000) chk({nm, "_timeout"}, 0, 1);
        repeat (2) @(negedge clock);
    endtask

    task automatic check_draws(input string nm, input vec_t v);
        chk({nm, "_ndraw"}, dx.size(), v.nd);
        for (int k = 0; k < v.nd && k < dx.size(); k++) begin
            chk($sformatf("%s_x%0d", nm, k), dx[k], v.ex[k]);
            chk($sformatf("%s_y%0d", nm, k), dy[k], v.ey[k]);
            chk($sformatf("%s_c%0d", nm, k), dc[k], v.ec[k]);
        end
        chk({nm, "_trunc"}, truncated, v.tr);
        chk({nm, "_done_cnt"}, done_cnt, 1);
    endtask

    vec_t tbl[8];

    initial begin
        tbl[0] = mk("AB",    "AB",  10,  20, 2, 8, 8,   10, 20,  22, 20,  0, 0, 1'b0);
        tbl[1] = mk("ABC",   "ABC",  0,   0, 1, 2, 8,    0,  0,   6,  0,  0, 8, 1'b0);
        tbl[2] = mk("A\nB",  "AB",   0,   0, 1, 8, 8,    0,  0,   0,  8,  0, 0, 1'b0);
        tbl[3] = mk("ABCDE", "AB",   0,   0, 1, 1, 2,    0,  0,   0,  8,  0, 0, 1'b1);
        tbl[4] = mk("A B",   "AB",   5,   5, 3, 8, 8,    5,  5,  41,  5,  0, 0, 1'b0);
        tbl[5] = mk("AB",    "AB", 1020,  0, 15, 8, 8, 1020,  0,  86,  0,  0, 0, 1'b0);
        tbl[6] = mk("AB",    "AB",   0,   0, 1, 1, 2,    0,  0,   0,  8,  0, 0, 1'b0);
        tbl[7] = mk("AxB",   "AB",   0,   0, 1, 8, 8,    0,  0,  12,  0,  0, 0, 1'b0);
        tbl[7].txt[1] = 8'h01;

        repeat (3) @(negedge clock);
        chk("rst_flags", {28'd0, busy, done, cr_enable, truncated}, 0);
        chk("rst_regs", {2'd0, mem_addr, char_out, 16'd0}, 0);
        chk("rst_origin", {12'd0, cr_origin_x, cr_origin_y}, 0);
        resetn = 1'b1;
        repeat (2) @(negedge clock);

        for (int i = 0; i < 8; i++) begin
            launch(tbl[i]);
            wait_done($sformatf("v%0d", i));
            check_draws($sformatf("v%0d", i), tbl[i]);
        end

        // Empty string: done on the second cycle after start, nothing drawn.
        dx.delete(); done_cnt = 0;
        text_len = 7'd0; start = 1'b1;
        @(negedge clock); start = 1'b0;
        chk("len0_busy_c1", busy, 1);
        chk("len0_done_c1", done, 0);
        @(negedge clock);
        chk("len0_done_c2", done, 1);
        @(negedge clock);
        chk("len0_done_c3", done, 0);
        chk("len0_busy_c3", busy, 0);
        chk("len0_ndraw", dx.size(), 0);

        // Start while busy must not disturb the running job.
        launch(tbl[0]);
        repeat (3) @(negedge clock);
        base_x = 10'd100; base_y = 10'd100; size = 4'd1; text_len = 7'd1;
        start = 1'b1;
        @(negedge clock); start = 1'b0;
        wait_done("busy_start");
        check_draws("busy_start", tbl[0]);

        // Abort during the first glyph: renderer completes, two release cycles, then done.
        begin
            int t = 0, k = 0;
            launch(tbl[1]);
            while (!cr_enable && t < 100) begin @(negedge clock); t++; end
            chk("abort_draw_seen", cr_enable, 1);
            abort = 1'b1;
            t = 0;
            while (cr_enable && t < 100) begin @(negedge clock); t++; end
            while (!done && k < 10) begin
                if (cr_enable) chk("abort_en_low", cr_enable, 0);
                @(negedge clock); k++;
            end
            chk("abort_fall_to_done", k, 3);
            abort = 1'b0;
            repeat (2) @(negedge clock);
            chk("abort_ndraw", dx.size(), 1);
            chk("abort_trunc", truncated, 0);
            chk("abort_busy", busy, 0);
        end

        // Reset mid-draw clears outputs without a clock edge; a later job runs normally.
        begin
            int t = 0;
            launch(tbl[0]);
            while (!cr_enable && t < 100) begin @(negedge clock); t++; end
            chk("rstmid_draw_seen", cr_enable, 1);
            #2 resetn = 1'b0;
            #1;
            chk("rstmid_flags", {28'd0, busy, done, cr_enable, truncated}, 0);
            chk("rstmid_regs", {2'd0, mem_addr, char_out, 16'd0}, 0);
            chk("rstmid_origin", {12'd0, cr_origin_x, cr_origin_y}, 0);
            repeat (2) @(negedge clock);
            resetn = 1'b1;
            @(negedge clock);
            launch(tbl[0]);
            wait_done("after_rst");
            check_draws("after_rst", tbl[0]);
        end

        chk("enable_rise_after_fall", rise_viol, 0);

        $display("== %0d vectors applied, %0d miscompares ==", nchk, nerr);
        $finish;
    end
endmodule
